// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and encodings for the SDRAM port arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACTIVE = 2'd2
  } arb_state_t;

  localparam int   HADDR_WIDTH_DEF = 25;
  localparam logic CMD_RD          = 1'b0;
  localparam logic CMD_WR          = 1'b1;

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester-side request/response bundle for sdram_arbiter
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF
);
  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_we;
  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*8-1:0]           req_wdata;
  logic [NUM_PORTS-1:0]             req_ready;
  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [7:0]                       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sdram_arb_rr_pick.sv
// rtl/sdram_arb_rr_pick.sv - combinational round-robin picker, search starts at ptr+1
module sdram_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      automatic int p = (int'(ptr) + i) % N;
      if (!any && req[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = PW'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one byte-wide SDRAM controller among NUM_PORTS requesters
// Optional SDRAM_ARB_PRIO_EN: port 0 becomes strict high priority over the round-robin ports.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF,
  parameter int PTR_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_arbiter_if.slave         bus,
  output logic [HADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]             mem_wr_data,
  output logic                   mem_wr_enable,
  output logic [HADDR_WIDTH-1:0] mem_rd_addr,
  output logic                   mem_rd_enable,
  input  logic [7:0]             mem_rd_data,
  input  logic                   mem_rd_ready,
  input  logic                   mem_busy
);

  arb_state_t             state_q, state_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   win_q, win_d;
  logic                   we_q, we_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   ready_q, ready_d;
  logic [NUM_PORTS-1:0]   rsp_q, rsp_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;

  logic [NUM_PORTS-1:0]   pick_gnt;
  logic [PTR_WIDTH-1:0]   pick_idx;
  logic                   pick_any;
  logic                   pick_move_ptr;

`ifdef SDRAM_ARB_PRIO_EN
  logic [NUM_PORTS-1:0] rr_gnt;
  logic [PTR_WIDTH-1:0] rr_idx;
  logic                 rr_any;

  // Port 0 is excluded from the rotation; it never moves the pointer.
  sdram_arb_rr_pick #(.N(NUM_PORTS), .PW(PTR_WIDTH)) u_pick (
    .req (bus.req_valid & {{(NUM_PORTS-1){1'b1}}, 1'b0}),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    pick_gnt      = rr_gnt;
    pick_idx      = rr_idx;
    pick_any      = rr_any;
    pick_move_ptr = 1'b1;
    if (bus.req_valid[0]) begin
      pick_gnt      = NUM_PORTS'(1);
      pick_idx      = '0;
      pick_any      = 1'b1;
      pick_move_ptr = 1'b0;
    end
  end
`else
  sdram_arb_rr_pick #(.N(NUM_PORTS), .PW(PTR_WIDTH)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_move_ptr = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = '0;
    rsp_d   = '0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          if (pick_move_ptr) ptr_d = pick_idx;
          we_d    = bus.req_we[pick_idx];
          addr_d  = bus.req_addr[pick_idx*HADDR_WIDTH +: HADDR_WIDTH];
          wdata_d = bus.req_wdata[pick_idx*8 +: 8];
          ready_d = pick_gnt;
          rd_en_d = (bus.req_we[pick_idx] == CMD_RD);
          wr_en_d = (bus.req_we[pick_idx] == CMD_WR);
        end
      end
      ISSUE: begin
        // Enable stays up through refresh; busy is the only acceptance indication.
        if (mem_busy) begin
          state_d = ACTIVE;
        end else begin
          rd_en_d = (we_q == CMD_RD);
          wr_en_d = (we_q == CMD_WR);
        end
      end
      ACTIVE: begin
        if (mem_rd_ready) rdata_d = mem_rd_data;
        if (!mem_busy) begin
          rsp_d[win_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_WIDTH'(NUM_PORTS - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      rsp_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign mem_wr_addr   = addr_q;
  assign mem_rd_addr   = addr_q;
  assign mem_wr_data   = wdata_q;
  assign mem_wr_enable = wr_en_q;
  assign mem_rd_enable = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter with a behavioural controller model
module tb_sdram_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 25;
  localparam int ACC = 4;

  typedef struct { logic [3:0] v; logic [7:0] d; int t; } obs_t;
  typedef struct { int p; logic [7:0] d; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_PORTS(NP), .HADDR_WIDTH(AW)) bus ();

  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [7:0]    mem_wr_data, mem_rd_data;
  logic          mem_wr_enable, mem_rd_enable, mem_rd_ready, mem_busy;

  sdram_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .PTR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
    .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready), .mem_busy(mem_busy)
  );

  // Controller model: enable ignored for refresh_cfg cycles, then busy for ACC cycles.
  logic [7:0] mem_arr [0:255];
  int   busy_cnt, en_wait, hold_at_accept;
  int   exec_count = 0;
  int   refresh_cfg = 0;
  logic op_rd;
  logic [7:0] op_addr;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_busy <= 1'b0; mem_rd_ready <= 1'b0; mem_rd_data <= 8'h00;
      busy_cnt <= 0; en_wait <= 0; op_rd <= 1'b0; op_addr <= 8'h00;
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
    end else begin
      mem_rd_ready <= 1'b0;
      if (mem_busy) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 2 && op_rd) begin
          mem_rd_ready <= 1'b1;
          mem_rd_data  <= mem_arr[op_addr];
        end
        if (busy_cnt == 1) mem_busy <= 1'b0;
      end else if (mem_rd_enable || mem_wr_enable) begin
        if (en_wait < refresh_cfg) begin
          en_wait <= en_wait + 1;
        end else begin
          mem_busy       <= 1'b1;
          busy_cnt       <= ACC;
          hold_at_accept <= en_wait;
          en_wait        <= 0;
          exec_count     <= exec_count + 1;
          op_rd          <= mem_rd_enable;
          op_addr        <= mem_rd_enable ? mem_rd_addr[7:0] : mem_wr_addr[7:0];
          if (mem_wr_enable) mem_arr[mem_wr_addr[7:0]] <= mem_wr_data;
        end
      end
    end
  end

  // Monitor only records DUT events; tasks do the comparing.
  int   cyc = 0;
  int   both_hi = 0;
  obs_t obs_g[$];
  obs_t obs_r[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.req_ready != 0) obs_g.push_back('{v: bus.req_ready, d: 8'h00, t: cyc});
    if (bus.rsp_valid != 0) obs_r.push_back('{v: bus.rsp_valid, d: bus.rsp_rdata, t: cyc});
    if (mem_rd_enable && mem_wr_enable) both_hi++;
  end

  int         total = 0;
  int         bad = 0;
  int         exp_g[$];
  exp_t       exp_r[$];
  logic [7:0] last_rd = 8'h00;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    bus.req_we[p]               = we;
    bus.req_addr[p*AW +: AW]    = a;
    bus.req_wdata[p*8 +: 8]     = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) tick();
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_bus: got %0h want 0", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata});
    end
    total++;
    if ({mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr, mem_wr_data} !== '0) begin
      bad++; $display("FAIL reset_mem: got %0h want 0", {mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr, mem_wr_data});
    end
  endtask

  task automatic test_round_robin();
    int t;
    obs_t o; exp_t e; int g;
    int order [6];
`ifdef SDRAM_ARB_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0, 1};
`endif
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), 8'(8'h10 + p));
    foreach (order[i]) begin exp_g.push_back(order[i]); exp_r.push_back('{p: order[i], d: last_rd}); end
    bus.req_valid = '1;
    rst_n = 1'b1;
    t = 0;
    while (obs_g.size() < 6 && t < 300) begin tick(); t++; end
    bus.req_valid = '0;
    while (obs_r.size() < 6 && t < 600) begin tick(); t++; end
    total++;
    if (t >= 600) begin bad++; $display("FAIL rr_timeout: got %0d cycles want <600", t); end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      g = exp_g.pop_front(); o = obs_g.pop_front();
      total++;
      if (o.v !== 4'(1 << g)) begin bad++; $display("FAIL rr_grant: got %b want %b", o.v, 4'(1 << g)); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++;
      if (o.v !== 4'(1 << e.p)) begin bad++; $display("FAIL rr_rsp: got %b want %b", o.v, 4'(1 << e.p)); end
    end
    total++;
    if (exp_g.size() + exp_r.size() + obs_g.size() + obs_r.size() != 0) begin
      bad++; $display("FAIL rr_leftover: got %0d want 0", exp_g.size() + exp_r.size() + obs_g.size() + obs_r.size());
    end
    exp_g.delete(); exp_r.delete(); obs_g.delete(); obs_r.delete();
  endtask

  task automatic test_single_write();
    int t, ex0, gt;
    obs_t o; exp_t e;
    ex0 = exec_count;
    set_port(2, 1'b1, 25'h0001234, 8'hA5);
    exp_r.push_back('{p: 2, d: last_rd});
    bus.req_valid[2] = 1'b1;
    tick();
    total++;
    if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL wr_ready: got %b want 0100", bus.req_ready); end
    total++;
    if ({mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr, mem_wr_data} !== {2'b10, 25'h0001234, 25'h0001234, 8'hA5}) begin
      bad++; $display("FAIL wr_issue: got %0h want %0h", {mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr, mem_wr_data},
                      {2'b10, 25'h0001234, 25'h0001234, 8'hA5});
    end
    bus.req_valid[2] = 1'b0;
    gt = (obs_g.size() > 0) ? obs_g[0].t : 0;
    t = 0;
    while (obs_r.size() < 1 && t < 100) begin tick(); t++; end
    total++;
    if (obs_r.size() != 1) begin bad++; $display("FAIL wr_rsp_count: got %0d want 1", obs_r.size()); end
    if (obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++;
      if (o.v !== 4'(1 << e.p)) begin bad++; $display("FAIL wr_rsp_port: got %b want %b", o.v, 4'(1 << e.p)); end
      total++;
      if (o.t - gt != ACC + 2) begin bad++; $display("FAIL wr_latency: got %0d want %0d", o.t - gt, ACC + 2); end
    end
    total++;
    if (exec_count - ex0 != 1) begin bad++; $display("FAIL wr_exec: got %0d want 1", exec_count - ex0); end
    exp_r.delete(); obs_g.delete(); obs_r.delete();
  endtask

  task automatic test_single_read();
    int t;
    obs_t o; exp_t e;
    set_port(1, 1'b0, 25'h0001234, 8'h00);
    last_rd = 8'hA5;
    exp_r.push_back('{p: 1, d: 8'hA5});
    bus.req_valid[1] = 1'b1;
    t = 0;
    while (obs_g.size() < 1 && t < 20) begin tick(); t++; end
    bus.req_valid[1] = 1'b0;
    while (obs_r.size() < 1 && t < 100) begin tick(); t++; end
    total++;
    if (obs_r.size() != 1) begin bad++; $display("FAIL rd_rsp_count: got %0d want 1", obs_r.size()); end
    if (obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++;
      if (o.v !== 4'(1 << e.p)) begin bad++; $display("FAIL rd_rsp_port: got %b want %b", o.v, 4'(1 << e.p)); end
      total++;
      if (o.d !== e.d) begin bad++; $display("FAIL rd_data: got %h want %h", o.d, e.d); end
    end
    total++;
    if (both_hi != 0) begin bad++; $display("FAIL rd_wr_overlap: got %0d want 0", both_hi); end
    exp_r.delete(); obs_g.delete(); obs_r.delete();
  endtask

  task automatic test_refresh();
    int t, ex0;
    obs_t o; exp_t e;
    ex0 = exec_count;
    refresh_cfg = 12;
    set_port(3, 1'b1, 25'h0000055, 8'h3C);
    exp_r.push_back('{p: 3, d: last_rd});
    bus.req_valid[3] = 1'b1;
    t = 0;
    while (obs_g.size() < 1 && t < 20) begin tick(); t++; end
    bus.req_valid[3] = 1'b0;
    while (obs_r.size() < 1 && t < 150) begin tick(); t++; end
    repeat (10) tick();
    refresh_cfg = 0;
    total++;
    if (hold_at_accept != 12) begin bad++; $display("FAIL ref_hold: got %0d want 12", hold_at_accept); end
    total++;
    if (exec_count - ex0 != 1) begin bad++; $display("FAIL ref_exec: got %0d want 1", exec_count - ex0); end
    total++;
    if (obs_r.size() != 1) begin bad++; $display("FAIL ref_rsp_count: got %0d want 1", obs_r.size()); end
    if (obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++;
      if ({o.v, o.d} !== {4'(1 << e.p), e.d}) begin
        bad++; $display("FAIL ref_rsp: got %b/%h want %b/%h", o.v, o.d, 4'(1 << e.p), e.d);
      end
    end
    exp_r.delete(); obs_g.delete(); obs_r.delete();
  endtask

  task automatic test_reset_mid();
    int t, g;
    obs_t o; exp_t e;
    set_port(2, 1'b0, 25'h0000001, 8'h00);
    bus.req_valid[2] = 1'b1;
    t = 0;
    while (obs_g.size() < 1 && t < 20) begin tick(); t++; end
    bus.req_valid[2] = 1'b0;
    while (!mem_busy && t < 60) begin tick(); t++; end
    tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_wr_data} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got %0h want 0",
                      {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_wr_data});
    end
    rst_n = 1'b1;
    obs_g.delete();
    repeat (10) tick();
    total++;
    if (obs_r.size() + obs_g.size() != 0) begin
      bad++; $display("FAIL mid_reset_quiet: got %0d want 0", obs_r.size() + obs_g.size());
    end
    last_rd = 8'h00;
    for (int p = 0; p < NP; p++) begin
      set_port(p, 1'b1, AW'(8'h40 + p), 8'(8'h60 + p));
      exp_g.push_back(p);
      exp_r.push_back('{p: p, d: last_rd});
    end
    bus.req_valid = '1;
    t = 0;
    while (obs_g.size() < 1 && t < 20) begin tick(); t++; end
    bus.req_valid[0] = 1'b0;
    while (obs_g.size() < 4 && t < 200) begin tick(); t++; end
    bus.req_valid = '0;
    while (obs_r.size() < 4 && t < 400) begin tick(); t++; end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      g = exp_g.pop_front(); o = obs_g.pop_front();
      total++;
      if (o.v !== 4'(1 << g)) begin bad++; $display("FAIL mid_fresh_grant: got %b want %b", o.v, 4'(1 << g)); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front();
      total++;
      if ({o.v, o.d} !== {4'(1 << e.p), e.d}) begin
        bad++; $display("FAIL mid_fresh_rsp: got %b/%h want %b/%h", o.v, o.d, 4'(1 << e.p), e.d);
      end
    end
    total++;
    if (exp_g.size() + exp_r.size() != 0) begin
      bad++; $display("FAIL mid_fresh_missing: got %0d want 0", exp_g.size() + exp_r.size());
    end
    exp_g.delete(); exp_r.delete(); obs_g.delete(); obs_r.delete();
  endtask

  task automatic test_prio();
    int t, g;
    obs_t o;
    int order [4];
`ifdef SDRAM_ARB_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 3, 0, 3};
`endif
    set_port(0, 1'b1, 25'h0000070, 8'h70);
    set_port(3, 1'b1, 25'h0000073, 8'h73);
    foreach (order[i]) exp_g.push_back(order[i]);
    bus.req_valid = 4'b1001;
    t = 0;
    while (obs_g.size() < 4 && t < 200) begin tick(); t++; end
    bus.req_valid = '0;
    while (obs_r.size() < 4 && t < 400) begin tick(); t++; end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      g = exp_g.pop_front(); o = obs_g.pop_front();
      total++;
      if (o.v !== 4'(1 << g)) begin bad++; $display("FAIL prio_grant: got %b want %b", o.v, 4'(1 << g)); end
    end
    total++;
    if (exp_g.size() != 0 || obs_r.size() != 4) begin
      bad++; $display("FAIL prio_counts: got %0d/%0d want 0/4", exp_g.size(), obs_r.size());
    end
    exp_g.delete(); obs_g.delete(); obs_r.delete();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_refresh();
    test_reset_mid();
    test_prio();
    total++;
    if (both_hi != 0) begin bad++; $display("FAIL rd_wr_overlap_final: got %0d want 0", both_hi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
